// File: rtl/ir_transmitter_pkg.sv
// Shared IR frame protocol definitions: FSM state encodings, frame unit constants and timer sizing.
// Used by ir_transmitter and ir_carrier_gen (carrier only under IR_TX_CARRIER_EN).
package ir_transmitter_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_PAUSE = 3'd2,
        S_BIT   = 3'd3,
        S_TRAIL = 3'd4
    } state_t;

    localparam int START_UNITS      = 4;
    localparam int ZERO_UNITS       = 1;
    localparam int ONE_UNITS        = 2;
    localparam int PAUSE_UNITS      = 1;
    // Receiver accepts pulse widths within this percentage of nominal.
    localparam int RX_TOLERANCE_PCT = 1;

    // The longest interval the timer must hold is either the trailing space or the start mark.
    function automatic int timer_width(input int base_pulse_width, input int trail_units);
        int w;
        if (trail_units >= 4) begin
            w = $clog2(trail_units * base_pulse_width + 1);
        end else begin
            w = $clog2(START_UNITS * base_pulse_width + 1);
        end
        return w;
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier modulator for IR marks; instantiated by ir_transmitter only when IR_TX_CARRIER_EN is defined.
// Phase restarts on every mark so each mark begins with the "on" half (ir_out=0).
module ir_carrier_gen
    import ir_transmitter_pkg::*;
#(
    parameter int CARRIER_PERIOD = 1250
) (
    input  logic clk,
    input  logic rst,
    input  logic mark_next,
    output logic ir_out
);

    localparam int PW = (CARRIER_PERIOD > 2) ? $clog2(CARRIER_PERIOD) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(CARRIER_PERIOD - 1);
    localparam logic [PW-1:0] PHASE_HALF = PW'(CARRIER_PERIOD / 2);
    localparam logic [PW-1:0] PHASE_ONE  = PW'(1);

    logic          mark_r;
    logic [PW-1:0] phase_r;
    logic [PW-1:0] phase_next_s;

    // Next carrier phase: zero at the first cycle of a mark, free-running modulo the period afterwards.
    always_comb begin
        phase_next_s = '0;
        if (mark_next && mark_r) begin
            if (phase_r == PHASE_LAST) begin
                phase_next_s = '0;
            end else begin
                phase_next_s = phase_r + PHASE_ONE;
            end
        end else begin
            phase_next_s = '0;
        end
    end

    // Registered modulated line: low during the first half of each carrier period inside a mark.
    always_ff @(posedge clk) begin
        if (rst) begin
            mark_r  <= 1'b0;
            phase_r <= '0;
            ir_out  <= 1'b1;
        end else begin
            mark_r  <= mark_next;
            phase_r <= phase_next_s;
            if (mark_next) begin
                ir_out <= (phase_next_s >= PHASE_HALF);
            end else begin
                ir_out <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ir_transmitter.sv
// Pulse-width IR frame transmitter: 4T start mark, per bit 1T space + 1T/2T mark, trailing space.
// Define IR_TX_CARRIER_EN to modulate marks with a square-wave carrier (envelope timing unchanged).
module ir_transmitter
    import ir_transmitter_pkg::*;
#(
    parameter int BASE_PULSE_WIDTH = 30000,
    parameter int DATA_BITS        = 12,
    parameter int TRAIL_UNITS      = 3,
    parameter int CARRIER_PERIOD   = 1250
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 ir_out
);

    localparam int TW = timer_width(BASE_PULSE_WIDTH, TRAIL_UNITS);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] START_LAST = TW'(START_UNITS * BASE_PULSE_WIDTH - 1);
    localparam logic [TW-1:0] PAUSE_LAST = TW'(PAUSE_UNITS * BASE_PULSE_WIDTH - 1);
    localparam logic [TW-1:0] ZERO_LAST  = TW'(ZERO_UNITS * BASE_PULSE_WIDTH - 1);
    localparam logic [TW-1:0] ONE_LAST   = TW'(ONE_UNITS * BASE_PULSE_WIDTH - 1);
    localparam logic [TW-1:0] TRAIL_LAST = TW'(TRAIL_UNITS * BASE_PULSE_WIDTH - 1);
    localparam logic [TW-1:0] TRAIL_PRE  = TW'(TRAIL_UNITS * BASE_PULSE_WIDTH - 2);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE    = BW'(1);

    if (BASE_PULSE_WIDTH < 2 || DATA_BITS != 12 || TRAIL_UNITS < 3 || CARRIER_PERIOD < 2) begin : g_bad_params
        $error("ir_transmitter: parameter out of range");
    end

    state_t               state_r;
    logic [TW-1:0]        timer_r;
    logic [BW-1:0]        bit_cnt_r;
    logic [DATA_BITS-1:0] shreg_r;

    logic start_end_s;
    logic pause_end_s;
    logic bit_end_s;
    logic trail_end_s;
    logic trail_pre_s;
    logic mark_next_s;

    // Exact end-of-interval compares; the timer is cleared on every transition so it never wraps.
    always_comb begin
        start_end_s = (timer_r == START_LAST);
        pause_end_s = (timer_r == PAUSE_LAST);
        bit_end_s   = shreg_r[DATA_BITS-1] ? (timer_r == ONE_LAST) : (timer_r == ZERO_LAST);
        trail_end_s = (timer_r == TRAIL_LAST);
        trail_pre_s = (timer_r == TRAIL_PRE);
    end

    // Envelope of the next cycle (1 = mark), so the line register changes together with the state.
    always_comb begin
        mark_next_s = 1'b0;
        case (state_r)
            S_IDLE:  mark_next_s = start;
            S_START: mark_next_s = !start_end_s;
            S_PAUSE: mark_next_s = pause_end_s;
            S_BIT:   mark_next_s = !bit_end_s;
            S_TRAIL: mark_next_s = 1'b0;
            default: mark_next_s = 1'b0;
        endcase
    end

    // Frame sequencer with registered busy/done; done is raised one cycle early so it lands on the last trail cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            timer_r   <= '0;
            bit_cnt_r <= '0;
            shreg_r   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done    <= 1'b0;
                    timer_r <= '0;
                    if (start) begin
                        shreg_r   <= data;
                        bit_cnt_r <= '0;
                        busy      <= 1'b1;
                        state_r   <= S_START;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_START: begin
                    if (start_end_s) begin
                        timer_r <= '0;
                        state_r <= S_PAUSE;
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                S_PAUSE: begin
                    if (pause_end_s) begin
                        timer_r <= '0;
                        state_r <= S_BIT;
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                S_BIT: begin
                    if (bit_end_s) begin
                        timer_r   <= '0;
                        shreg_r   <= {shreg_r[DATA_BITS-2:0], 1'b0};
                        bit_cnt_r <= bit_cnt_r + BIT_ONE;
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r <= S_TRAIL;
                        end else begin
                            state_r <= S_PAUSE;
                        end
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                S_TRAIL: begin
                    if (trail_end_s) begin
                        timer_r <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                        done    <= trail_pre_s;
                    end
                end
                default: begin
                    timer_r <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

`ifdef IR_TX_CARRIER_EN
    ir_carrier_gen #(
        .CARRIER_PERIOD(CARRIER_PERIOD)
    ) u_carrier (
        .clk       (clk),
        .rst       (rst),
        .mark_next (mark_next_s),
        .ir_out    (ir_out)
    );
`else
    logic ir_r;

    // Baseband line register: low for marks, high for spaces and idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_r <= 1'b1;
        end else begin
            ir_r <= !mark_next_s;
        end
    end

    assign ir_out = ir_r;
`endif

endmodule

// File: tb/tb_ir_transmitter.sv
// Self-checking bench for ir_transmitter with T=10: per-cycle comparison of ir_out/busy/done
// against a waveform list built from the frame rules (carrier-aware when IR_TX_CARRIER_EN is defined).
module tb_ir_transmitter;

    localparam int T  = 10;
    localparam int CP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] data;
    logic        start;
    logic        busy;
    logic        done;
    logic        ir_out;

    int n_cmp  = 0;
    int n_fail = 0;
    bit exp_ir[$];

    ir_transmitter #(
        .BASE_PULSE_WIDTH (T),
        .DATA_BITS        (12),
        .TRAIL_UNITS      (3),
        .CARRIER_PERIOD   (CP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .data   (data),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .ir_out (ir_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_seg(input bit mark, input int cycles);
        for (int i = 0; i < cycles; i++) begin
`ifdef IR_TX_CARRIER_EN
            exp_ir.push_back(mark ? ((i % CP) >= (CP / 2)) : 1'b1);
`else
            exp_ir.push_back(!mark);
`endif
        end
    endtask

    task automatic build_model(input logic [11:0] d);
        exp_ir.delete();
        push_seg(1'b1, 4 * T);
        for (int b = 11; b >= 0; b--) begin
            push_seg(1'b0, T);
            push_seg(1'b1, d[b] ? 2 * T : T);
        end
        push_seg(1'b0, 3 * T);
    endtask

    // mode 0: single start pulse; 1: extra starts at cycle 5 and on done plus data noise; 2: start held, next data loaded at the end
    task automatic run_frame(input logic [11:0] d, input int mode, input logic [11:0] next_d,
                             input bit lead, output int done_cycle);
        int       len;
        logic [2:0] got;
        logic [2:0] expv;
        build_model(d);
        len = exp_ir.size();
        done_cycle = 0;
        if (lead) begin
            @(negedge clk);
            data  = d;
            start = 1'b1;
        end
        for (int n = 1; n <= len + 1; n++) begin
            @(negedge clk);
            if (n <= len) expv = {exp_ir[n-1], 1'b1, (n == len)};
            else          expv = 3'b100;
            got = {ir_out, busy, done};
            n_cmp++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL frame d=%h cycle %0d: ir/busy/done got %b want %b", d, n, got, expv);
            end
            if (done === 1'b1 && done_cycle == 0) done_cycle = n;
            case (mode)
                1: begin
                    start = (n == 5) || (n == len);
                    data  = 12'($urandom);
                end
                2: begin
                    start = 1'b1;
                    if (n == len + 1) data = next_d;
                end
                default: start = 1'b0;
            endcase
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; data = 12'h000;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ir_out, busy, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_state: got %b want 100", {ir_out, busy, done});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ir_out, busy, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b want 100", {ir_out, busy, done});
        end
    endtask

    task automatic test_all_zeros();
        int dc;
        run_frame(12'h000, 0, 12'h000, 1'b1, dc);
        n_cmp++;
        if (dc != 310) begin
            n_fail++;
            $display("FAIL zeros_done_cycle: got %0d want 310", dc);
        end
    endtask

    task automatic test_all_ones();
        int dc;
        run_frame(12'hFFF, 0, 12'h000, 1'b1, dc);
        n_cmp++;
        if (dc != 430) begin
            n_fail++;
            $display("FAIL ones_done_cycle: got %0d want 430", dc);
        end
    endtask

    task automatic test_random();
        int          dc;
        logic [11:0] d;
        for (int k = 0; k < 4; k++) begin
            d = 12'($urandom);
            run_frame(d, 0, 12'h000, 1'b1, dc);
            n_cmp++;
            if (dc != 10 * (4 + 12 + $countones(d) + 12 + 3)) begin
                n_fail++;
                $display("FAIL random_done_cycle d=%h: got %0d want %0d", d, dc, 10 * (31 + $countones(d)));
            end
        end
    endtask

    task automatic test_ignored_start();
        int dc;
        run_frame(12'hA5C, 1, 12'h000, 1'b1, dc);
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({ir_out, busy, done} !== 3'b100) begin
                n_fail++;
                $display("FAIL ignored_start_idle: got %b want 100", {ir_out, busy, done});
            end
        end
    endtask

    task automatic test_midframe_reset();
        int          c;
        int          dc;
        logic [11:0] d;
        d = 12'($urandom);
        build_model(d);
        c = 4 * T + (T + (d[11] ? 2 * T : T)) + (T + (d[10] ? 2 * T : T)) + T + 2;
        @(negedge clk);
        data = d; start = 1'b1;
        for (int n = 1; n <= c; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        n_cmp++;
        if ({ir_out, busy} !== {exp_ir[c-1], 1'b1}) begin
            n_fail++;
            $display("FAIL in_third_mark: ir/busy got %b want %b", {ir_out, busy}, {exp_ir[c-1], 1'b1});
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({ir_out, busy, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL abort_on_reset: got %b want 100", {ir_out, busy, done});
        end
        rst = 1'b0;
        run_frame(~d, 0, 12'h000, 1'b1, dc);
    endtask

    task automatic test_back_to_back();
        int          dc;
        logic [11:0] d1;
        logic [11:0] d2;
        d1 = 12'($urandom);
        d2 = 12'($urandom);
        run_frame(d1, 2, d2, 1'b1, dc);
        run_frame(d2, 0, 12'h000, 1'b0, dc);
        n_cmp++;
        if (dc != 10 * (31 + $countones(d2))) begin
            n_fail++;
            $display("FAIL back_to_back_done: got %0d want %0d", dc, 10 * (31 + $countones(d2)));
        end
    endtask

    initial begin
        test_reset();
        test_all_zeros();
        test_all_ones();
        test_random();
        test_ignored_start();
        test_midframe_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
